// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch/branch controller for the program counter. Runs the
//            memory fetch handshake and issues increment/load strobes.
//            Optional return-address stack enabled by PC_SEQ_STACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic [WIDTH-1:0] pc_val,
    input  logic             mem_ack,
    input  logic             dec_jmp,
    input  logic             dec_call,
    input  logic             dec_ret,
    input  logic [WIDTH-1:0] dec_target,
    output logic             pc_en,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_load_val,
    output logic             pc_oe,
    output logic             mem_req,
    output logic             busy,
    output logic             fault
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2
    } t_state;

    t_state             r_state_q, w_state_d;
    logic               r_pc_en_q, w_pc_en_d;
    logic               r_pc_load_q, w_pc_load_d;
    logic [WIDTH-1:0]   r_pc_load_val_q, w_pc_load_val_d;
    logic               r_mem_req_q, w_mem_req_d;
    logic               r_pc_oe_q, w_pc_oe_d;
    logic               r_busy_q, w_busy_d;
    logic               r_fault_q, w_fault_d;
    logic               r_halt_q, w_halt_d;
    logic               r_err_q, w_err_d;

`ifdef PC_SEQ_STACK_EN
    localparam int            SPW       = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] c_SP_ONE = SPW'(1);
    localparam logic [SPW-1:0] c_FULL   = SPW'(STACK_DEPTH);
    localparam logic [WIDTH-1:0] c_PC_ONE = WIDTH'(1);

    logic [WIDTH-1:0]   r_stack_q [STACK_DEPTH];
    logic [SPW-1:0]     r_sp_q, w_sp_d;
    logic [SPW-1:0]     w_sp_m1;
    logic               w_push;
    logic [WIDTH-1:0]   w_pc_inc;

    assign w_sp_m1  = r_sp_q - c_SP_ONE;
    assign w_pc_inc = pc_val + c_PC_ONE;
`else
    logic w_unused_ret;
    assign w_unused_ret = dec_ret;
`endif

    always_comb begin
        w_state_d       = r_state_q;
        w_pc_en_d       = 1'b0;
        w_pc_load_d     = 1'b0;
        w_pc_load_val_d = '0;
        w_mem_req_d     = 1'b0;
        w_pc_oe_d       = 1'b0;
        w_busy_d        = 1'b0;
        w_fault_d       = r_fault_q;
        w_halt_d        = 1'b0;
        w_err_d         = 1'b0;
`ifdef PC_SEQ_STACK_EN
        w_sp_d          = r_sp_q;
        w_push          = 1'b0;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (start && !r_fault_q) begin
                    w_state_d   = S_FETCH;
                    w_mem_req_d = 1'b1;
                    w_pc_oe_d   = 1'b1;
                    w_busy_d    = 1'b1;
                end
            end
            S_FETCH: begin
                w_busy_d = 1'b1;
                w_halt_d = r_halt_q | halt;
                if (mem_ack) begin
                    // Action is resolved here so UPDATE strobes come straight from flops.
                    w_state_d = S_UPDATE;
`ifdef PC_SEQ_STACK_EN
                    if (dec_ret) begin
                        if (r_sp_q == '0) begin
                            w_fault_d = 1'b1;
                            w_err_d   = 1'b1;
                        end else begin
                            w_pc_load_d     = 1'b1;
                            w_pc_load_val_d = r_stack_q[w_sp_m1[SPW-2:0]];
                            w_sp_d          = w_sp_m1;
                        end
                    end else if (dec_call) begin
                        if (r_sp_q == c_FULL) begin
                            w_fault_d = 1'b1;
                            w_err_d   = 1'b1;
                        end else begin
                            w_push          = 1'b1;
                            w_sp_d          = r_sp_q + c_SP_ONE;
                            w_pc_load_d     = 1'b1;
                            w_pc_load_val_d = dec_target;
                        end
                    end else if (dec_jmp) begin
                        w_pc_load_d     = 1'b1;
                        w_pc_load_val_d = dec_target;
                    end else begin
                        w_pc_en_d = 1'b1;
                    end
`else
                    if (dec_jmp || dec_call) begin
                        w_pc_load_d     = 1'b1;
                        w_pc_load_val_d = dec_target;
                    end else begin
                        w_pc_en_d = 1'b1;
                    end
`endif
                end else begin
                    w_mem_req_d = 1'b1;
                    w_pc_oe_d   = 1'b1;
                end
            end
            S_UPDATE: begin
                if (r_err_q || r_halt_q || halt) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_state_d   = S_FETCH;
                    w_mem_req_d = 1'b1;
                    w_pc_oe_d   = 1'b1;
                    w_busy_d    = 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_pc_en_q       <= 1'b0;
            r_pc_load_q     <= 1'b0;
            r_pc_load_val_q <= '0;
            r_mem_req_q     <= 1'b0;
            r_pc_oe_q       <= 1'b0;
            r_busy_q        <= 1'b0;
            r_fault_q       <= 1'b0;
            r_halt_q        <= 1'b0;
            r_err_q         <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_pc_en_q       <= w_pc_en_d;
            r_pc_load_q     <= w_pc_load_d;
            r_pc_load_val_q <= w_pc_load_val_d;
            r_mem_req_q     <= w_mem_req_d;
            r_pc_oe_q       <= w_pc_oe_d;
            r_busy_q        <= w_busy_d;
            r_fault_q       <= w_fault_d;
            r_halt_q        <= w_halt_d;
            r_err_q         <= w_err_d;
        end
    end

`ifdef PC_SEQ_STACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack_q[i] <= '0;
            end
        end else begin
            r_sp_q <= w_sp_d;
            if (w_push) begin
                r_stack_q[r_sp_q[SPW-2:0]] <= w_pc_inc;
            end
        end
    end
`endif

    assign pc_en       = r_pc_en_q;
    assign pc_load     = r_pc_load_q;
    assign pc_load_val = r_pc_load_val_q;
    assign pc_oe       = r_pc_oe_q;
    assign mem_req     = r_mem_req_q;
    assign busy        = r_busy_q;
    assign fault       = r_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed vector bench for pc_sequencer (both stack configurations).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, halt, mem_ack, dec_jmp, dec_call, dec_ret;
    logic [7:0] pc_val, dec_target, pc_load_val;
    logic       pc_en, pc_load, pc_oe, mem_req, busy, fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_val(pc_val),
        .mem_ack(mem_ack), .dec_jmp(dec_jmp), .dec_call(dec_call),
        .dec_ret(dec_ret), .dec_target(dec_target), .pc_en(pc_en),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_oe(pc_oe),
        .mem_req(mem_req), .busy(busy), .fault(fault)
    );

    typedef struct {
        logic       st, ack, jmp, call, ret, hlt;
        logic [7:0] pc, tgt;
        logic       e_en, e_ld;
        logic [7:0] e_val;
        logic       e_req, e_busy, e_fault;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        start = 0; halt = 0; mem_ack = 0; dec_jmp = 0; dec_call = 0; dec_ret = 0;
        pc_val = 8'h00; dec_target = 8'h00;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic set_vec(input logic st, ack, jmp, call, ret, hlt,
                           input logic [7:0] pc, tgt,
                           input logic e_en, e_ld, input logic [7:0] e_val,
                           input logic e_req, e_busy, e_fault, input int idx);
        vecs[idx] = '{st, ack, jmp, call, ret, hlt, pc, tgt, e_en, e_ld, e_val, e_req, e_busy, e_fault};
    endtask

    initial begin
        int pulses [$];
        int loads;
        int nfetch;

        //       st ack jmp cal ret hlt pc     tgt    en ld        val    req bsy flt
        set_vec(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 1, 1, 0, 0);
        set_vec(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0,        8'h00, 0, 1, 0, 1);
        set_vec(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 1, 1, 0, 2);
        set_vec(0, 1, 1, 0, 0, 0, 8'h10, 8'h80, 0, 1,        8'h80, 0, 1, 0, 3);
        set_vec(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 1, 1, 0, 4);
        set_vec(0, 1, 0, 1, 0, 0, 8'hFF, 8'h20, 0, 1,        8'h20, 0, 1, 0, 5);
        set_vec(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 1, 1, 0, 6);
        set_vec(0, 1, 0, 0, 1, 0, 8'h20, 8'h55, !STK, STK,   8'h00, 0, 1, 0, 7);
        set_vec(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 1, 1, 0, 8);
        set_vec(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0,        8'h00, 0, 1, 0, 9);
        set_vec(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 0, 0, 0, 10);
        set_vec(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0,        8'h00, 0, 0, 0, 11);

        do_reset();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_load_val", pc_load_val, 0);
        chk("rst_pc_oe", pc_oe, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].st; mem_ack = vecs[i].ack; dec_jmp = vecs[i].jmp;
            dec_call = vecs[i].call; dec_ret = vecs[i].ret; halt = vecs[i].hlt;
            pc_val = vecs[i].pc; dec_target = vecs[i].tgt;
            step();
            chk($sformatf("v%0d_pc_en", i), pc_en, vecs[i].e_en);
            chk($sformatf("v%0d_pc_load", i), pc_load, vecs[i].e_ld);
            if (vecs[i].e_ld) chk($sformatf("v%0d_load_val", i), pc_load_val, vecs[i].e_val);
            chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
            chk($sformatf("v%0d_pc_oe", i), pc_oe, vecs[i].e_req);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_fault", i), fault, vecs[i].e_fault);
            chk($sformatf("v%0d_excl", i), pc_en & pc_load, 0);
        end

        // Three back-to-back instructions with ack in the first FETCH cycle
        do_reset();
        start = 1;
        loads = 0;
        nfetch = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (pc_en) pulses.push_back(c);
            if (pc_load) loads++;
            start = 0;
            mem_ack = mem_req && (nfetch < 3);
            halt = mem_req && (nfetch == 2);
            if (mem_req) nfetch++;
        end
        clr_in();
        chk("inc_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("inc_spacing_a", pulses[1] - pulses[0], 2);
            chk("inc_spacing_b", pulses[2] - pulses[1], 2);
        end
        chk("inc_no_load", loads, 0);
        chk("inc_end_busy", busy, 0);

        // Five calls against a 4-deep stack
        do_reset();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1; dec_call = 1; dec_target = 8'h30 + 8'(i); pc_val = 8'(i);
            halt = (i == 4);
            step();
            clr_in();
            chk($sformatf("call%0d_load", i), pc_load, (STK && i == 4) ? 0 : 1);
            if (pc_load) chk($sformatf("call%0d_val", i), pc_load_val, 8'h30 + i);
            chk($sformatf("call%0d_fault", i), fault, (STK && i == 4) ? 1 : 0);
            step();
        end
        chk("call_end_busy", busy, 0);
        start = 1;
        step();
        chk("call_start_ignored", mem_req, STK ? 0 : 1);
        step();
        clr_in();

        // Halt mid-FETCH with a slow acknowledge
        do_reset();
        start = 1;
        step();
        start = 0;
        chk("halt_req_c1", mem_req, 1);
        halt = 1;
        step();
        halt = 0;
        chk("halt_req_c2", mem_req, 1);
        step();
        chk("halt_req_c3", mem_req, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("halt_update_en", pc_en, 1);
        chk("halt_update_req", mem_req, 0);
        step();
        chk("halt_end_busy", busy, 0);
        chk("halt_no_extra_en", pc_en, 0);
        step();
        chk("halt_stays_idle", mem_req, 0);

        // Reset during FETCH clears an occupied stack
        do_reset();
        start = 1;
        step();
        start = 0;
        mem_ack = 1; dec_call = 1; dec_target = 8'h44; pc_val = 8'h05;
        step();
        clr_in();
        step();
        chk("rstf_in_fetch", mem_req, 1);
        rst = 1;
        step();
        rst = 0;
        chk("rstf_mem_req", mem_req, 0);
        chk("rstf_busy", busy, 0);
        chk("rstf_fault", fault, 0);
        start = 1;
        step();
        start = 0;
        mem_ack = 1; dec_ret = 1;
        step();
        clr_in();
        chk("rstf_ret_load", pc_load, 0);
        chk("rstf_ret_en", pc_en, STK ? 0 : 1);
        chk("rstf_ret_fault", fault, STK);
        step();
        chk("rstf_after_busy", busy, STK ? 0 : 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/branch controller for the 8-bit program counter. Drives the counter's increment, load and output-enable controls, runs a request/acknowledge fetch handshake with instruction memory, and resolves jump/call/return decisions once per instruction. Sits between the program counter and instruction memory and decode, and owns an optional hardware return-address stack.

## Interface
- `WIDTH`, 8: program-counter width in bits.
- `STACK_DEPTH`, 4: return-stack entries (power of two, 2..16).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `start`  in  1  begin sequencing from the current PC (level, sampled in IDLE)
- `halt`  in  1  stop after the current instruction completes
- `pc_val`  in  WIDTH  current counter value (feedback from counter)
- `mem_ack`  in  1  memory has returned the instruction at `pc_val`
- `dec_jmp`, `dec_call`, `dec_ret`  in  1 each  decode results, valid in the `mem_ack` cycle
- `dec_target`  in  WIDTH  jump/call target, valid in the `mem_ack` cycle
- `pc_en`  out  1  counter increment strobe
- `pc_load`  out  1  counter load strobe
- `pc_load_val`  out  WIDTH  value to load
- `pc_oe`  out  1  counter output enable
- `mem_req`  out  1  fetch request
- `busy`  out  1  state is not IDLE
- `fault`  out  1  sticky stack error

## Operation
- States: IDLE, FETCH, UPDATE.
- IDLE: all strobes low. `start=1` and `fault=0` -> FETCH.
- FETCH: `mem_req=1` and `pc_oe=1`. The block holds FETCH until `mem_ack=1`. In the ack cycle it registers the decode inputs and `pc_val`, then moves to UPDATE.
- UPDATE lasts one cycle. Exactly one action is taken, in priority order ret > call > jmp > increment:
  - ret: pop the stack top, `pc_load=1`, `pc_load_val`=popped value.
  - call: push `pc_val+1` (mod 2^WIDTH), `pc_load=1`, `pc_load_val=dec_target`.
  - jmp: `pc_load=1`, `pc_load_val=dec_target`.
  - otherwise: `pc_en=1`.
- UPDATE next state: IDLE if `halt` was seen at any point since the instruction's FETCH began (halt is latched); otherwise FETCH.
- Halt never aborts an open handshake. FETCH always waits for `mem_ack`.
- `pc_load` and `pc_en` are never both high.
- Wrap-around: increment at 0xFF is left to the counter (it wraps to 0x00). A call at 0xFF pushes 0x00.
- Stack errors:
  - A call with the stack full sets `fault`. No push, no load; the next state is IDLE.
  - A ret with the stack empty sets `fault`. No load; the next state is IDLE.
- `fault` clears only on `rst`. `start` is ignored while `fault=1`.
- Stack contents persist across IDLE/start and are cleared by `rst`.

## Timing
- Reset values: state IDLE, stack empty, halt latch 0. `pc_en=0`, `pc_load=0`, `pc_load_val=0`, `pc_oe=0`, `mem_req=0`, `busy=0`, `fault=0`.
- `rst` overrides everything, including an open handshake. `mem_req` drops the cycle after `rst` is sampled.
- `start` sampled at edge N -> `mem_req=1` from cycle N+1.
- `mem_ack` at edge M -> UPDATE during cycle M+1 with the strobe asserted. The counter takes the new value at edge M+2, and the next FETCH begins in cycle M+2.
- Minimum instruction period: 2 cycles (ack in the first FETCH cycle).
- All outputs are registered-state decodes. The UPDATE strobes depend only on registered decode data.
- `mem_ack` outside FETCH is ignored.

## Configuration
- `PC_SEQ_STACK_EN` defined: return stack, call/ret handling and stack faults are present, as described above.
- `PC_SEQ_STACK_EN` not defined: no stack storage. `dec_call` behaves as `dec_jmp`, and `dec_ret` is ignored (the instruction increments). `fault` is tied to 0.

## Test plan
- Reset, then `start`, with `mem_ack` returned 1 cycle after each `mem_req` and no decode flags, for 3 instructions -> exactly 3 `pc_en` pulses, each 1 cycle wide, spaced 2 cycles apart; `pc_load` stays 0.
- With `pc_val=0x10`, assert `dec_jmp` and `dec_target=0x80` in the ack cycle -> next cycle `pc_load=1`, `pc_load_val=0x80`, `pc_en=0`.
- Call at `pc_val=0xFF` with target 0x20, then ret -> first `pc_load_val=0x20`, second `pc_load_val=0x00`, `fault=0`.
- Issue 5 calls with `STACK_DEPTH=4` -> 4 loads; on the 5th, `fault=1`, no load, state IDLE, and later `start` is ignored until `rst`.
- Raise `halt` mid-FETCH with ack delayed 3 cycles -> `mem_req` held until ack, one UPDATE strobe, then `busy=0`.
- Assert `rst` during FETCH -> the next cycle has `mem_req=0`, `busy=0`, `fault=0`, and the stack is empty (a following ret faults).
